// File: rtl/fetch_queue_pkg.sv
// Shared defines for the instruction fetch queue: bus widths, NOP encoding,
// fetch sequencing state and pointer sizing helper.
package fetch_queue_pkg;

   localparam int unsigned INST_ADDR_W = 32;
   localparam int unsigned BUS_W       = 32;
   localparam logic [BUS_W-1:0] NOP_INST = '0;
   localparam int unsigned PC_STEP     = 4;

   typedef enum logic {
      FETCH_OFF = 1'b0,
      FETCH_ON  = 1'b1
   } fetch_state_e;

   // Index width for a DEPTH-entry store; a 1-entry store still needs one bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: DEPTH x WIDTH, one synchronous write
// port and one asynchronous read port.
module fq_ram
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        wr_en_i,
   input  logic [ptr_width(DEPTH)-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]            wr_data_i,
   input  logic [ptr_width(DEPTH)-1:0] rd_addr_i,
   output logic [WIDTH-1:0]            rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between a combinational ROM and the ID stage.
// Optional build macro FETCH_DELAY_SLOT_EN keeps one delay-slot entry on a
// taken branch instead of flushing the whole queue.
//
// state     | meaning
// FETCH_OFF | in reset or first cycle after release, no ROM reads
// FETCH_ON  | fetching whenever the queue has room or is draining
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       ADDR_W   = INST_ADDR_W,
   parameter int unsigned       INST_W   = BUS_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     rom_ce_o,
   output logic [ADDR_W-1:0]        rom_addr_o,
   input  logic [INST_W-1:0]        rom_data_i,
   input  logic                     stall_i,
   input  logic                     branch_flag_i,
   input  logic [ADDR_W-1:0]        branch_target_address_i,
   output logic                     id_valid_o,
   output logic [ADDR_W-1:0]        id_pc_o,
   output logic [INST_W-1:0]        id_inst_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W   = ptr_width(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = ADDR_W + INST_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_state_e      fetch_state_q;
   logic [ADDR_W-1:0] pc_q,    pc_d;
   logic [PTR_W-1:0]  head_q,  head_d;
   logic [PTR_W-1:0]  tail_q,  tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              empty;
   logic              full;
   logic              deq;
   logic              redirect;
   logic              rom_ce;
   logic              wr_en;
   logic [ENTRY_W-1:0] wr_data;
   logic [ENTRY_W-1:0] rd_data;
   logic [ADDR_W-1:0] rd_pc;
   logic [INST_W-1:0] rd_inst;

   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == FULL_CNT);
      deq      = !empty && !stall_i;
      redirect = deq && branch_flag_i;
      rom_ce   = (fetch_state_q == FETCH_ON) && (!full || deq);

      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      wr_en   = 1'b0;

      if (redirect) begin
         pc_d = branch_target_address_i;
`ifdef FETCH_DELAY_SLOT_EN
         // The entry behind the branch is the delay slot; if it is not queued
         // yet, it is the word being read from ROM right now.
         if (count_q >= CNT_W'(2)) begin
            head_d  = head_q + PTR_W'(1);
            tail_d  = head_q + PTR_W'(1) + PTR_W'(1);
            count_d = CNT_W'(1);
         end else if (rom_ce) begin
            wr_en   = 1'b1;
            head_d  = tail_q;
            tail_d  = tail_q + PTR_W'(1);
            count_d = CNT_W'(1);
         end else begin
            head_d  = tail_q;
            count_d = '0;
         end
`else
         head_d  = tail_q;
         count_d = '0;
`endif
      end else begin
         if (deq) begin
            head_d = head_q + PTR_W'(1);
         end
         if (rom_ce) begin
            wr_en  = 1'b1;
            tail_d = tail_q + PTR_W'(1);
            pc_d   = pc_q + ADDR_W'(PC_STEP);
         end
         unique case ({rom_ce, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_state_q <= FETCH_OFF;
         pc_q          <= RESET_PC;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
      end else begin
         fetch_state_q <= FETCH_ON;
         pc_q          <= pc_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
      end
   end

   assign wr_data = {pc_q, rom_data_i};

   fq_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fq_ram (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (tail_q),
      .wr_data_i (wr_data),
      .rd_addr_i (head_q),
      .rd_data_o (rd_data)
   );

   assign rd_pc   = rd_data[ENTRY_W-1:INST_W];
   assign rd_inst = rd_data[INST_W-1:0];

   // An empty queue presents a NOP at PC 0 so ID never sees stale storage.
   assign rom_ce_o   = rom_ce;
   assign rom_addr_o = pc_q;
   assign id_valid_o = !empty;
   assign id_pc_o    = empty ? '0 : rd_pc;
   assign id_inst_o  = empty ? INST_W'(NOP_INST) : rd_inst;
   assign count_o    = count_q;

endmodule
